tx_resp_arbiter: RTL and testbench

- Sits in the REF_CLK domain between the system controller's response sources and the TX async FIFO write port.
- Captures ALU results (16-bit, split into two bytes) and register-file read data (8-bit) into one holding slot per source.
- Arbitrates round-robin between the two slots and serializes bytes into the FIFO using the winc/wfull handshake.
- Reports dropped responses through a sticky error flag.

---
 rtl/tx_resp_arbiter.sv | 150 +++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter: collects ALU results and register-file read data into one
// holding slot per source. It arbitrates between the two slots round-robin and
// writes their bytes into the TX FIFO using the winc/wfull handshake.
// Optional build macro: TX_ARB_FRAME_TAG_EN. When it is defined, every response
// is preceded by a tag byte: 0xA1 for ALU and 0xB2 for RD.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | nothing granted; arbitrate on pending slots
// RD_B     | presenting the RD slot byte
// ALU_LO   | presenting ALU slot bits [7:0]
// ALU_HI   | presenting ALU slot bits [15:8], last ALU byte
// TAG_ALU  | (tag build) presenting 0xA1 ahead of ALU bytes
// TAG_RD   | (tag build) presenting 0xB2 ahead of the RD byte
module tx_resp_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ALU_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ALU_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_Valid,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   input  logic                  wfull,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] TX_P_Data,
   output logic                  TX_D_VLD,
   output logic                  alu_pend,
   output logic                  rd_pend,
   output logic                  drop_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_B,
      S_ALU_LO,
      S_ALU_HI
`ifdef TX_ARB_FRAME_TAG_EN
      , S_TAG_ALU
      , S_TAG_RD
`endif
   } state_t;

`ifdef TX_ARB_FRAME_TAG_EN
   localparam logic [DATA_WIDTH-1:0] TAG_ALU_BYTE = DATA_WIDTH'(8'hA1);
   localparam logic [DATA_WIDTH-1:0] TAG_RD_BYTE  = DATA_WIDTH'(8'hB2);
   localparam state_t ALU_FIRST = S_TAG_ALU;
   localparam state_t RD_FIRST  = S_TAG_RD;
`else
   localparam state_t ALU_FIRST = S_ALU_LO;
   localparam state_t RD_FIRST  = S_RD_B;
`endif

   state_t                state_q, state_d;
   logic [ALU_WIDTH-1:0]  alu_q, alu_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic                  alu_pend_q, alu_pend_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  last_rd_q, last_rd_d;   // 1: last grant went to RD
   logic                  drop_err_q, drop_err_d;

   logic xfer, alu_rel, rd_rel, avail_alu, avail_rd, pick_alu;
   logic alu_cap, rd_cap, alu_drop, rd_drop;

   // Handshake, slot release, arbitration and next-state selection.
   always_comb begin
      xfer      = (state_q != S_IDLE) & ~wfull;
      alu_rel   = xfer & (state_q == S_ALU_HI);
      rd_rel    = xfer & (state_q == S_RD_B);
      // A slot that releases on this edge is no longer a candidate for the next grant.
      avail_alu = alu_pend_q & ~alu_rel;
      avail_rd  = rd_pend_q & ~rd_rel;
      pick_alu  = avail_alu & (~avail_rd | last_rd_q);
      state_d   = state_q;
      last_rd_d = last_rd_q;
      if ((state_q == S_IDLE) | alu_rel | rd_rel) begin
         if (avail_alu | avail_rd) begin
            state_d   = pick_alu ? ALU_FIRST : RD_FIRST;
            last_rd_d = ~pick_alu;
         end else begin
            state_d = S_IDLE;
         end
      end else if (xfer) begin
         case (state_q)
            S_ALU_LO:  state_d = S_ALU_HI;
`ifdef TX_ARB_FRAME_TAG_EN
            S_TAG_ALU: state_d = S_ALU_LO;
            S_TAG_RD:  state_d = S_RD_B;
`endif
            default:   state_d = state_q;
         endcase
      end
   end

   // Slot capture and drop detection; a slot that is releasing counts as empty.
   always_comb begin
      alu_cap    = OUT_Valid & (~alu_pend_q | alu_rel);
      rd_cap     = RdData_Valid & (~rd_pend_q | rd_rel);
      alu_drop   = OUT_Valid & alu_pend_q & ~alu_rel;
      rd_drop    = RdData_Valid & rd_pend_q & ~rd_rel;
      alu_d      = alu_cap ? ALU_OUT : alu_q;
      rd_d       = rd_cap ? RdData : rd_q;
      alu_pend_d = alu_cap | (alu_pend_q & ~alu_rel);
      rd_pend_d  = rd_cap | (rd_pend_q & ~rd_rel);
      drop_err_d = alu_drop | rd_drop | (drop_err_q & ~clr_err);
   end

   // Byte mux toward the FIFO.
   always_comb begin
      TX_D_VLD  = xfer;
      TX_P_Data = '0;
      case (state_q)
         S_RD_B:    TX_P_Data = rd_q;
         S_ALU_LO:  TX_P_Data = alu_q[DATA_WIDTH-1:0];
         S_ALU_HI:  TX_P_Data = alu_q[ALU_WIDTH-1:DATA_WIDTH];
`ifdef TX_ARB_FRAME_TAG_EN
         S_TAG_ALU: TX_P_Data = TAG_ALU_BYTE;
         S_TAG_RD:  TX_P_Data = TAG_RD_BYTE;
`endif
         default:   TX_P_Data = '0;
      endcase
   end

   assign alu_pend = alu_pend_q;
   assign rd_pend  = rd_pend_q;
   assign drop_err = drop_err_q;

   // State and slot registers. Reset abandons any frame in progress.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         alu_q      <= '0;
         rd_q       <= '0;
         alu_pend_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         last_rd_q  <= 1'b1;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_q      <= alu_d;
         rd_q       <= rd_d;
         alu_pend_q <= alu_pend_d;
         rd_pend_q  <= rd_pend_d;
         last_rd_q  <= last_rd_d;
         drop_err_q <= drop_err_d;
      end
   end

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Testbench for tx_resp_arbiter. The vector table covers one clock cycle per
// row. Inputs are driven after the falling edge, and the outputs are checked
// 1 ns later, before the next rising edge.
module tb_tx_resp_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] ALU_OUT;
   logic        OUT_Valid;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic        wfull;
   logic        clr_err;
   logic [7:0]  TX_P_Data;
   logic        TX_D_VLD;
   logic        alu_pend;
   logic        rd_pend;
   logic        drop_err;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
      .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
      .RdData(RdData), .RdData_Valid(RdData_Valid), .wfull(wfull),
      .clr_err(clr_err), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
      .alu_pend(alu_pend), .rd_pend(rd_pend), .drop_err(drop_err)
   );

   typedef struct {
      logic        rst;
      logic        ov;
      logic [15:0] alu;
      logic        rv;
      logic [7:0]  rd;
      logic        wf;
      logic        clr;
      logic        vld;
      logic [7:0]  data;
      logic        ap;
      logic        rp;
      logic        err;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  got[$];
   logic [7:0]  expq[$];

   function automatic void add(logic rst, logic ov, logic [15:0] alu, logic rv,
                               logic [7:0] rd, logic wf, logic clr, logic vld,
                               logic [7:0] data, logic ap, logic rp, logic err);
      vec_t v;
      v.rst = rst; v.ov = ov; v.alu = alu; v.rv = rv; v.rd = rd; v.wf = wf;
      v.clr = clr; v.vld = vld; v.data = data; v.ap = ap; v.rp = rp; v.err = err;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic zero_inputs();
      OUT_Valid = 0; ALU_OUT = '0; RdData_Valid = 0; RdData = '0;
      wfull = 0; clr_err = 0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 0;
      zero_inputs();
      repeat (2) @(negedge CLK);
      RST = 1;
   endtask

   // A single pulse on cycle 0, then records every written byte for ncyc cycles.
   task automatic collect(input string name, input logic ap, input logic [15:0] a,
                          input logic rp, input logic [7:0] r, input int ncyc);
      int first_w = -1;
      int last_w  = -1;
      got.delete();
      for (int k = 0; k < ncyc; k++) begin
         @(negedge CLK);
         OUT_Valid    = (k == 0) & ap;
         ALU_OUT      = a;
         RdData_Valid = (k == 0) & rp;
         RdData       = r;
         #1;
         if (TX_D_VLD) begin
            got.push_back(TX_P_Data);
            if (first_w < 0) first_w = k;
            last_w = k;
         end
      end
      check({name, " count"}, 16'(got.size()), 16'(expq.size()));
      for (int i = 0; i < expq.size(); i++)
         check($sformatf("%s byte%0d", name, i), (i < got.size()) ? {8'h0, got[i]} : 16'hFFFF, {8'h0, expq[i]});
      check({name, " back-to-back"}, 16'(last_w - first_w + 1), 16'(expq.size()));
   endtask

   initial begin
      int guard;
      RST = 0;
      zero_inputs();
      #12;
      check("reset TX_D_VLD", {15'h0, TX_D_VLD}, 16'h0);
      check("reset TX_P_Data", {8'h0, TX_P_Data}, 16'h0);
      check("reset pend/err", {13'h0, alu_pend, rd_pend, drop_err}, 16'h0);
      @(negedge CLK);
      RST = 1;

`ifndef TX_ARB_FRAME_TAG_EN
      // Simultaneous pair after reset: ALU wins the first tie (last grant reset to RD).
      add(1,1,16'hBEEF,1,8'h5A,0,0, 0,8'h00,0,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,1,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'hEF,1,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'hBE,1,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h5A,0,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // Lone ALU 0x1234: grant leaves last grant = ALU.
      add(0,1,16'h1234,0,8'h00,0,0, 0,8'h00,0,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h34,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h12,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // Pair with last grant = ALU: RD goes first, ALU follows with no IDLE bubble.
      add(0,1,16'h1234,1,8'h5B,0,0, 0,8'h00,0,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,1,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h5B,1,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h34,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h12,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // wfull held 5 cycles during ALU_HI.
      add(0,1,16'hBEEF,0,8'h00,0,0, 0,8'h00,0,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'hEF,1,0,0);
      for (int i = 0; i < 5; i++)
         add(0,0,16'h0,0,8'h00,1,0, 0,8'hBE,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'hBE,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // ALU drop keeps original bytes; clr_err clears.
      add(0,1,16'h1357,0,8'h00,0,0, 0,8'h00,0,0,0);
      add(0,1,16'h2468,0,8'h00,0,0, 0,8'h00,1,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h57,1,0,1);
      add(0,0,16'h0,0,8'h00,0,1,    1,8'h13,1,0,1);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // RD drop coincident with clr_err: set wins.
      add(0,0,16'h0,1,8'h66,1,0,    0,8'h00,0,0,0);
      add(0,0,16'h0,1,8'h99,1,1,    0,8'h00,0,1,0);
      add(0,0,16'h0,0,8'h00,1,0,    0,8'h66,0,1,1);
      add(0,0,16'h0,0,8'h00,0,1,    1,8'h66,0,1,1);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);
      // Capture and release of the RD slot on one edge: no drop.
      add(0,0,16'h0,1,8'h10,0,0,    0,8'h00,0,0,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,1,0);
      add(0,0,16'h0,1,8'h20,0,0,    1,8'h10,0,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    1,8'h20,0,1,0);
      add(0,0,16'h0,0,8'h00,0,0,    0,8'h00,0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         @(negedge CLK);
         OUT_Valid = vecs[i].ov; ALU_OUT = vecs[i].alu;
         RdData_Valid = vecs[i].rv; RdData = vecs[i].rd;
         wfull = vecs[i].wf; clr_err = vecs[i].clr;
         #1;
         check($sformatf("v%0d TX_D_VLD", i), {15'h0, TX_D_VLD}, {15'h0, vecs[i].vld});
         check($sformatf("v%0d TX_P_Data", i), {8'h0, TX_P_Data}, {8'h0, vecs[i].data});
         check($sformatf("v%0d alu_pend", i), {15'h0, alu_pend}, {15'h0, vecs[i].ap});
         check($sformatf("v%0d rd_pend", i), {15'h0, rd_pend}, {15'h0, vecs[i].rp});
         check($sformatf("v%0d drop_err", i), {15'h0, drop_err}, {15'h0, vecs[i].err});
      end
`endif

      // Reset asserted while the high ALU byte is presented.
      do_reset();
      @(negedge CLK);
      OUT_Valid = 1; ALU_OUT = 16'hBEEF;
      @(negedge CLK);
      OUT_Valid = 0;
      guard = 0;
      #1;
      while (TX_P_Data !== 8'hBE && guard < 10) begin
         @(negedge CLK);
         #1;
         guard++;
      end
      check("reach ALU_HI", {15'h0, guard < 10}, 16'h1);
      RST = 0;
      #1;
      check("midrst TX_D_VLD", {15'h0, TX_D_VLD}, 16'h0);
      check("midrst TX_P_Data", {8'h0, TX_P_Data}, 16'h0);
      check("midrst pend", {14'h0, alu_pend, rd_pend}, 16'h0);
      @(negedge CLK);
      RST = 1;
      expq.delete();
`ifdef TX_ARB_FRAME_TAG_EN
      expq.push_back(8'hB2);
`endif
      expq.push_back(8'h77);
      collect("after-reset RD", 0, 16'h0, 1, 8'h77, 8);

      expq.delete();
`ifdef TX_ARB_FRAME_TAG_EN
      expq.push_back(8'hA1);
`endif
      expq.push_back(8'h34);
      expq.push_back(8'h12);
      collect("ALU frame", 1, 16'h1234, 0, 8'h00, 8);
      check("final drop_err", {15'h0, drop_err}, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
